// File: rtl/mult_datapath_if.sv
// mult_datapath_if: control word, operand load and status/result bundle between controller and datapath
interface mult_datapath_if #(parameter int DATA_W = 16);
  logic [15:0]         i_ctrl;
  logic                i_load;
  logic [DATA_W/2-1:0] i_a;
  logic [DATA_W/2-1:0] i_b;
  logic                paridad;
  logic                compuor;
  logic                mayor;
  logic [DATA_W-1:0]   o_result;
  modport master (output i_ctrl, i_load, i_a, i_b, input paridad, compuor, mayor, o_result);
  modport slave  (input i_ctrl, i_load, i_a, i_b, output paridad, compuor, mayor, o_result);
endinterface

// File: rtl/mult_datapath.sv
// mult_datapath: register file, operand muxes, 8-function ALU and registered flags for the shift-and-add multiplier
module mult_datapath #(
  parameter int DATA_W  = 16,
  parameter int OUT_REG = 5
) (
  input logic            clk,
  input logic            rst,
  mult_datapath_if.slave bus
);
  logic [DATA_W-1:0] r_q [16];
  logic [2:0]        cnt_alu;
  logic [3:0]        slc_a, slc_b, slc_reg;
  logic              w;
  logic [DATA_W-1:0] op_a, op_b, alu_y;
  logic              paridad_q, compuor_q, mayor_q;
  assign {cnt_alu, slc_a, slc_b, slc_reg, w} = bus.i_ctrl;
  assign op_a = r_q[slc_a];
  assign op_b = r_q[slc_b];
  always_comb begin
    alu_y = cnt_alu == 3'd0 ? op_a + op_b :
            cnt_alu == 3'd1 ? op_a >> 1 :
            cnt_alu == 3'd2 ? op_a - op_b :
            cnt_alu == 3'd3 ? op_a << 1 :
            cnt_alu == 3'd4 ? op_a :
            cnt_alu == 3'd5 ? op_a & op_b :
            cnt_alu == 3'd6 ? op_a | op_b :
                              op_a ^ op_b;
  end
  // load wins over the ALU write; flags track the ALU every cycle regardless
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      paridad_q <= 1'b0;
      compuor_q <= 1'b0;
      mayor_q   <= 1'b0;
    end else begin
      paridad_q <= alu_y[0];
      compuor_q <= ~|alu_y;
      mayor_q   <= op_a > op_b;
      if (bus.i_load) begin
        r_q[1] <= {{(DATA_W/2){1'b0}}, bus.i_a};
        r_q[0] <= {{(DATA_W/2){1'b0}}, bus.i_b};
        r_q[5] <= '0;
      end else if (w) begin
        r_q[slc_reg] <= alu_y;
      end
    end
  end
  assign bus.paridad  = paridad_q;
  assign bus.compuor  = compuor_q;
  assign bus.mayor    = mayor_q;
  assign bus.o_result = r_q[OUT_REG];
endmodule
